// File: rtl/pulse_mon_pkg.sv
// Shared definitions for pulse_monitor: FSM state encoding and saturating-counter helpers.
// Counters up to MaxCntSize bits are supported.
package pulse_mon_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StGap    = 2'd2
    } pm_state_e;

    localparam int unsigned MaxCntSize = 32;

    typedef logic [MaxCntSize-1:0] cnt_t;

    // All-ones value of a counter that is `width` bits wide.
    function automatic cnt_t cnt_max(int unsigned width);
        cnt_t m;
        m = '0;
        for (int unsigned i = 0; i < MaxCntSize; i++) begin
            if (i < width) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic cnt_t sat_inc(cnt_t val, int unsigned width);
        return (val >= cnt_max(width)) ? val : val + cnt_t'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level; both stages reset to RESET_VALUE.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pulse_monitor.sv
// Measures width and preceding gap of each pulse and hands records out on a valid/ready port.
// Define PULSE_MONITOR_SYNC_EN to pass the pulse through a two-flop synchronizer first.
module pulse_monitor
    import pulse_mon_pkg::*;
#(
    parameter logic        INITIAL_VALUE  = 1'b0,
    parameter int unsigned CNT_SIZE       = 10,
    parameter int unsigned EXPECTED_WIDTH = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                pulse,
    input  logic                meas_ready,
    output logic                meas_valid,
    output logic [CNT_SIZE-1:0] meas_width,
    output logic [CNT_SIZE-1:0] meas_gap,
    output logic [CNT_SIZE-1:0] pulse_count,
    output logic                width_err,
    output logic                overflow,
    output logic                timeout
);

    typedef logic [CNT_SIZE-1:0] cnt_w_t;

    function automatic cnt_w_t inc(cnt_w_t v);
        return cnt_w_t'(sat_inc(cnt_t'(v), CNT_SIZE));
    endfunction

    logic pulse_s;

`ifdef PULSE_MONITOR_SYNC_EN
    sync_2ff #(
        .RESET_VALUE(INITIAL_VALUE)
    ) u_sync (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .d     (pulse),
        .q     (pulse_s)
    );
`else
    assign pulse_s = pulse;
`endif

    logic act;
    assign act = pulse_s ^ INITIAL_VALUE;

    pm_state_e state_q, state_d;
    cnt_w_t    width_q, width_d;
    cnt_w_t    gap_q, gap_d;
    cnt_w_t    start_gap_q, start_gap_d;
    cnt_w_t    count_q, count_d;
    cnt_w_t    rec_width_q, rec_width_d;
    cnt_w_t    rec_gap_q, rec_gap_d;
    logic      valid_q, valid_d;
    logic      werr_q, werr_d;
    logic      ovf_q, ovf_d;
    logic      tout_q, tout_d;
    logic      complete;
    logic      load;

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        gap_d       = gap_q;
        start_gap_d = start_gap_q;
        count_d     = count_q;
        rec_width_d = rec_width_q;
        rec_gap_d   = rec_gap_q;
        valid_d     = valid_q;
        werr_d      = werr_q;
        ovf_d       = ovf_q;
        tout_d      = tout_q;
        complete    = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            StIdle, StGap: begin
                if (act) begin
                    state_d     = StActive;
                    width_d     = cnt_w_t'(1);
                    start_gap_d = gap_q;
                    gap_d       = '0;
                end else begin
                    gap_d = inc(gap_q);
                end
            end
            StActive: begin
                if (act) begin
                    width_d = inc(width_q);
                end else begin
                    // The falling sample is already the first idle cycle of the next gap.
                    state_d  = StGap;
                    gap_d    = cnt_w_t'(1);
                    complete = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (TIMEOUT_CYCLES != 0 && state_d != StActive &&
            cnt_t'(gap_d) == cnt_t'(TIMEOUT_CYCLES)) begin
            tout_d = 1'b1;
        end

        if (complete) begin
            count_d = inc(count_q);
            if (EXPECTED_WIDTH != 0 && cnt_t'(width_q) != cnt_t'(EXPECTED_WIDTH)) begin
                werr_d = 1'b1;
            end
            // A pending record may be replaced only in the cycle it is being accepted.
            load = !valid_q || meas_ready;
            if (!load) begin
                ovf_d = 1'b1;
            end
        end

        if (load) begin
            valid_d     = 1'b1;
            rec_width_d = width_q;
            rec_gap_d   = start_gap_q;
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            width_q     <= '0;
            gap_q       <= '0;
            start_gap_q <= '0;
            count_q     <= '0;
            rec_width_q <= '0;
            rec_gap_q   <= '0;
            valid_q     <= 1'b0;
            werr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            gap_q       <= gap_d;
            start_gap_q <= start_gap_d;
            count_q     <= count_d;
            rec_width_q <= rec_width_d;
            rec_gap_q   <= rec_gap_d;
            valid_q     <= valid_d;
            werr_q      <= werr_d;
            ovf_q       <= ovf_d;
            tout_q      <= tout_d;
        end
    end

    assign meas_valid  = valid_q;
    assign meas_width  = rec_width_q;
    assign meas_gap    = rec_gap_q;
    assign pulse_count = count_q;
    assign width_err   = werr_q;
    assign overflow    = ovf_q;
    assign timeout     = tout_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Scoreboard bench for pulse_monitor: two instances (active-high with timeout, active-low with
// 4-bit saturating counters); records are checked on handshake, flags and timing inline.
module tb_pulse_monitor;

`ifdef PULSE_MONITOR_SYNC_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 0;
`endif

    typedef struct {
        int w;
        int g;
    } rec_t;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       rst_a, pulse_a, ready_a, mv_a, werr_a, ovf_a, to_a;
    logic [9:0] mw_a, mg_a, cnt_a;
    logic       rst_b, pulse_b, ready_b, mv_b, werr_b, ovf_b, to_b;
    logic [3:0] mw_b, mg_b, cnt_b;

    int   total = 0;
    int   bad   = 0;
    rec_t qa[$];
    rec_t qb[$];
    rec_t ea;
    rec_t eb;

    pulse_monitor #(
        .INITIAL_VALUE (1'b0),
        .CNT_SIZE      (10),
        .EXPECTED_WIDTH(1),
        .TIMEOUT_CYCLES(8)
    ) u_dut_a (
        .clk_in     (clk_in),
        .rst_n      (rst_a),
        .pulse      (pulse_a),
        .meas_ready (ready_a),
        .meas_valid (mv_a),
        .meas_width (mw_a),
        .meas_gap   (mg_a),
        .pulse_count(cnt_a),
        .width_err  (werr_a),
        .overflow   (ovf_a),
        .timeout    (to_a)
    );

    pulse_monitor #(
        .INITIAL_VALUE (1'b1),
        .CNT_SIZE      (4),
        .EXPECTED_WIDTH(2),
        .TIMEOUT_CYCLES(0)
    ) u_dut_b (
        .clk_in     (clk_in),
        .rst_n      (rst_b),
        .pulse      (pulse_b),
        .meas_ready (ready_b),
        .meas_valid (mv_b),
        .meas_width (mw_b),
        .meas_gap   (mg_b),
        .pulse_count(cnt_b),
        .width_err  (werr_b),
        .overflow   (ovf_b),
        .timeout    (to_b)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input int w, input int g);
        rec_t r;
        r.w = w;
        r.g = g;
        qa.push_back(r);
    endtask

    task automatic push_b(input int w, input int g);
        rec_t r;
        r.w = w;
        r.g = g;
        qb.push_back(r);
    endtask

    task automatic check_reset(input string tag, input int mv, input int mw, input int mg,
                               input int cnt, input int werr, input int ovf, input int to);
        check({tag, "_valid"}, mv, 0);
        check({tag, "_width"}, mw, 0);
        check({tag, "_gap"}, mg, 0);
        check({tag, "_count"}, cnt, 0);
        check({tag, "_werr"}, werr, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_timeout"}, to, 0);
    endtask

    // Six idle cycles on B; the record must appear exactly Lat+1 cycles after the release.
    task automatic idle6_b(input string tag);
        for (int i = 0; i < 6; i++) begin
            if (i == Lat) check({tag, "_valid_before"}, int'(mv_b), 0);
            tick();
            if (i == Lat) check({tag, "_valid"}, int'(mv_b), 1);
        end
    endtask

    always @(negedge clk_in) begin
        if (mv_a && ready_a) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_record: width=%0d gap=%0d, no record expected",
                         mw_a, mg_a);
            end else begin
                ea = qa.pop_front();
                check("a_rec_width", int'(mw_a), ea.w);
                check("a_rec_gap", int'(mg_a), ea.g);
            end
        end
        if (mv_b && ready_b) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_record: width=%0d gap=%0d, no record expected",
                         mw_b, mg_b);
            end else begin
                eb = qb.pop_front();
                check("b_rec_width", int'(mw_b), eb.w);
                check("b_rec_gap", int'(mg_b), eb.g);
            end
        end
    end

    initial begin
        rst_a   = 1'b0;
        pulse_a = 1'b0;
        ready_a = 1'b1;
        rst_b   = 1'b0;
        pulse_b = 1'b1;
        ready_b = 1'b1;
        ticks(2);
        check_reset("a_rst", int'(mv_a), int'(mw_a), int'(mg_a), int'(cnt_a), int'(werr_a),
                    int'(ovf_a), int'(to_a));

        // Timeout fires on the 8th idle cycle after reset release.
        rst_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) check("timeout_early", int'(to_a), 0);
        end
        check("timeout_at_8", int'(to_a), 1);

        // 5 idle, 3 active: width 3, gap 5, width error.
        rst_a = 1'b0;
        tick();
        check_reset("a_rst2", int'(mv_a), int'(mw_a), int'(mg_a), int'(cnt_a), int'(werr_a),
                    int'(ovf_a), int'(to_a));
        rst_a = 1'b1;
        push_a(3, 5 + Lat);
        ticks(5);
        pulse_a = 1'b1;
        ticks(3);
        pulse_a = 1'b0;
        ticks(Lat);
        check("s1_valid_before", int'(mv_a), 0);
        tick();
        check("s1_valid", int'(mv_a), 1);
        check("s1_count", int'(cnt_a), 1);
        check("s1_werr", int'(werr_a), 1);
        tick();
        check("s1_valid_cleared", int'(mv_a), 0);

        // Two 1-cycle pulses 4 cycles apart with consumer stalled: second dropped.
        rst_a = 1'b0;
        tick();
        rst_a   = 1'b1;
        ready_a = 1'b0;
        push_a(1, 2 + Lat);
        ticks(2);
        pulse_a = 1'b1;
        tick();
        pulse_a = 1'b0;
        ticks(3);
        pulse_a = 1'b1;
        tick();
        pulse_a = 1'b0;
        ticks(4 + Lat);
        check("s2_overflow", int'(ovf_a), 1);
        check("s2_count", int'(cnt_a), 2);
        check("s2_werr", int'(werr_a), 0);
        check("s2_held_valid", int'(mv_a), 1);
        check("s2_held_width", int'(mw_a), 1);
        check("s2_held_gap", int'(mg_a), 2 + Lat);
        check("s2_no_timeout", int'(to_a), 0);
        ready_a = 1'b1;
        tick();
        check("s2_valid_after_accept", int'(mv_a), 0);
        tick();
        check("s2_dropped_not_loaded", int'(mv_a), 0);

        // Completion in the same cycle as acceptance of the pending record.
        rst_a = 1'b0;
        tick();
        rst_a   = 1'b1;
        ready_a = 1'b0;
        push_a(2, 1 + Lat);
        push_a(1, 2);
        tick();
        pulse_a = 1'b1;
        ticks(2);
        pulse_a = 1'b0;
        ticks(2);
        pulse_a = 1'b1;
        tick();
        pulse_a = 1'b0;
        ticks(Lat);
        check("s3_pending_valid", int'(mv_a), 1);
        check("s3_pending_width", int'(mw_a), 2);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check("s3_overflow", int'(ovf_a), 0);
        check("s3_new_valid", int'(mv_a), 1);
        check("s3_new_width", int'(mw_a), 1);
        check("s3_new_gap", int'(mg_a), 2);
        check("s3_count", int'(cnt_a), 2);
        check("s3_werr", int'(werr_a), 1);
        ready_a = 1'b1;
        tick();
        check("s3_valid_cleared", int'(mv_a), 0);

        // Reset during cycle 2 of a 5-cycle pulse: only the last 3 cycles are measured.
        rst_a = 1'b0;
        tick();
        rst_a   = 1'b1;
        pulse_a = 1'b1;
        push_a(3, Lat);
        tick();
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        ticks(3);
        pulse_a = 1'b0;
        ticks(Lat);
        check("s4_valid_before", int'(mv_a), 0);
        tick();
        check("s4_valid", int'(mv_a), 1);
        check("s4_count", int'(cnt_a), 1);
        tick();

        // Instance B: active-low pulse, 4-bit counters, expected width 2, timeout disabled.
        check_reset("b_rst", int'(mv_b), int'(mw_b), int'(mg_b), int'(cnt_b), int'(werr_b),
                    int'(ovf_b), int'(to_b));
        rst_b = 1'b1;
        push_b(2, 3 + Lat);
        ticks(3);
        pulse_b = 1'b0;
        ticks(2);
        pulse_b = 1'b1;
        idle6_b("b1");
        check("b1_werr", int'(werr_b), 0);

        // Held active for 20 cycles: no record until release, width saturates at 15.
        push_b(15, 6);
        pulse_b = 1'b0;
        ticks(20);
        check("b2_held_no_record", int'(mv_b), 0);
        pulse_b = 1'b1;
        idle6_b("b2");
        check("b2_werr", int'(werr_b), 1);

        // 17 more pulses: pulse_count saturates at 15, back-to-back accepts never overflow.
        push_b(1, 6);
        for (int k = 0; k < 16; k++) push_b(1, 1);
        for (int k = 0; k < 17; k++) begin
            pulse_b = 1'b0;
            tick();
            pulse_b = 1'b1;
            tick();
        end
        ticks(Lat + 2);
        check("b3_count_sat", int'(cnt_b), 15);
        check("b3_overflow", int'(ovf_b), 0);
        ticks(20);
        check("b_timeout_disabled", int'(to_b), 0);

        ticks(Lat + 3);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
